// File: rtl/stim_pkg.sv
// Shared types and constants for the operand stimulus generator.
// Holds the FSM encoding, mode codes and the LFSR step function.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic MODE_EXH  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    localparam logic [15:0] LFSR_MASK          = 16'hB400;
    localparam logic [15:0] LFSR_SEED_FALLBACK = 16'h0001;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Galois LFSR register with synchronous load and step enable.
// Load has priority over stepping.
module stim_lfsr16
    import stim_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iLoad,
    input  logic [15:0] iSeed,
    input  logic        iEn,
    output logic [15:0] oState
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (iLoad) begin
            state_d = iSeed;
        end else if (iEn) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign oState = state_q;

endmodule

// File: rtl/operand_sequencer.sv
// Operand-pair generator: exhaustive count or LFSR vectors under valid/ready.
// Reports busy, a one-cycle done pulse and the number of accepted vectors.
module operand_sequencer
    import stim_pkg::*;
#(
    parameter int          WIDTH   = 1,
    parameter int          NUM_VEC = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iMode,
    input  logic             iReady,
    output logic [WIDTH-1:0] oA,
    output logic [WIDTH-1:0] oB,
    output logic             oValid,
    output logic             oBusy,
    output logic             oDone,
    output logic [15:0]      oCount
);

    localparam int VW = 2 * WIDTH;

    localparam logic [15:0] SEED_EFF =
        (SEED == 16'h0000) ? LFSR_SEED_FALLBACK : SEED;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [VW-1:0]   cnt_q, cnt_d;
    logic [15:0]     count_q, count_d;
    logic            lfsr_load;
    logic            lfsr_en;
    logic [15:0]     lfsr_s;
    logic            last_vec;
    logic [VW-1:0]   vec;
    logic            unused_lfsr_hi;

    stim_lfsr16 u_lfsr (
        .iClk   (iClk),
        .iRst   (iRst),
        .iLoad  (lfsr_load),
        .iSeed  (SEED_EFF),
        .iEn    (lfsr_en),
        .oState (lfsr_s)
    );

    assign unused_lfsr_hi = ^lfsr_s[15:VW];

    assign last_vec = (mode_q == MODE_LFSR) ? (count_q == LAST_IDX)
                                            : (&cnt_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    mode_d    = iMode;
                    cnt_d     = '0;
                    count_d   = '0;
                    lfsr_load = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iReady) begin
                    count_d = count_q + 16'd1;
                    if (last_vec) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + VW'(1);
                        lfsr_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_EXH;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Both sources are registers, so the operands never see iReady directly.
    assign vec    = (mode_q == MODE_LFSR) ? lfsr_s[VW-1:0] : cnt_q;
    assign oA     = vec[VW-1:WIDTH];
    assign oB     = vec[WIDTH-1:0];
    assign oValid = (state_q == ST_RUN);
    assign oBusy  = (state_q == ST_RUN);
    assign oDone  = (state_q == ST_DONE);
    assign oCount = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: exhaustive, LFSR, stall, reset, restart.
// A second instance covers the zero-seed fallback at WIDTH=7.
module tb_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, start0, mode0, ready0;
    logic [0:0]  a0, b0;
    logic        valid0, busy0, done0;
    logic [15:0] count0;

    logic        rst1, start1, mode1, ready1;
    logic [6:0]  a1, b1;
    logic        valid1, busy1, done1;
    logic [15:0] count1;

    int nvec = 0;
    int nerr = 0;

    operand_sequencer #(
        .WIDTH   (1),
        .NUM_VEC (16),
        .SEED    (16'hACE1)
    ) dut0 (
        .iClk   (clk),
        .iRst   (rst0),
        .iStart (start0),
        .iMode  (mode0),
        .iReady (ready0),
        .oA     (a0),
        .oB     (b0),
        .oValid (valid0),
        .oBusy  (busy0),
        .oDone  (done0),
        .oCount (count0)
    );

    operand_sequencer #(
        .WIDTH   (7),
        .NUM_VEC (5),
        .SEED    (16'h0000)
    ) dut1 (
        .iClk   (clk),
        .iRst   (rst1),
        .iStart (start1),
        .iMode  (mode1),
        .iReady (ready1),
        .oA     (a1),
        .oB     (b1),
        .oValid (valid1),
        .oBusy  (busy1),
        .oDone  (done1),
        .oCount (count1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nx(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Runs one dut0 sequence starting at a negedge; optional stall at vector sidx.
    task automatic run_seq(input bit md, input int n, input int sidx,
                           input int slen, input bit hold);
        logic [15:0] l;
        logic [1:0]  ev;
        l = 16'hACE1;
        start0 = 1'b1;
        mode0  = md;
        @(negedge clk);
        if (!hold) start0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            ev = md ? l[1:0] : 2'(i);
            chk($sformatf("vec%0d", i), {30'd0, a0, b0}, {30'd0, ev});
            chk($sformatf("valid%0d", i), {31'd0, valid0}, 32'd1);
            chk($sformatf("busy%0d", i), {31'd0, busy0}, 32'd1);
            chk($sformatf("cnt%0d", i), {16'd0, count0}, i);
            if (i == sidx) begin
                ready0 = 1'b0;
                for (int s = 0; s < slen; s++) begin
                    @(negedge clk);
                    chk($sformatf("hold%0d", s), {30'd0, a0, b0}, {30'd0, ev});
                    chk($sformatf("hvalid%0d", s), {31'd0, valid0}, 32'd1);
                    chk($sformatf("hcnt%0d", s), {16'd0, count0}, i);
                end
                ready0 = 1'b1;
            end
            l = nx(l);
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done0}, 32'd1);
        chk("done_valid", {31'd0, valid0}, 32'd0);
        chk("done_busy", {31'd0, busy0}, 32'd0);
        chk("done_cnt", {16'd0, count0}, n);
        @(negedge clk);
        chk("done_once", {31'd0, done0}, 32'd0);
        chk("idle_cnt", {16'd0, count0}, n);
    endtask

    logic [13:0] exp1 [5];

    initial begin
        exp1[0] = 14'h0001;
        exp1[1] = 14'h3400;
        exp1[2] = 14'h1A00;
        exp1[3] = 14'h2D00;
        exp1[4] = 14'h1680;
        rst0 = 1'b1; start0 = 1'b0; mode0 = 1'b0; ready0 = 1'b1;
        rst1 = 1'b1; start1 = 1'b0; mode1 = 1'b0; ready1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_ab", {30'd0, a0, b0}, 32'd0);
        chk("rst_cnt", {16'd0, count0}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        run_seq(1'b0, 4, -1, 0, 1'b0);
        run_seq(1'b0, 4, 1, 3, 1'b0);

        // LFSR first two vectors from the hand-worked seed values
        start0 = 1'b1; mode0 = 1'b1;
        ready0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        chk("lfsr_v0", {30'd0, a0, b0}, 32'd1);
        ready0 = 1'b1;
        @(negedge clk);
        chk("lfsr_v1", {30'd0, a0, b0}, 32'd0);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        run_seq(1'b1, 16, -1, 0, 1'b0);

        // Reset while vector 2 is on the outputs
        start0 = 1'b1; mode0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_vec", {30'd0, a0, b0}, 32'd2);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("mid_rst_valid", {31'd0, valid0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_cnt", {16'd0, count0}, 32'd0);
        chk("mid_rst_ab", {30'd0, a0, b0}, 32'd0);
        run_seq(1'b0, 4, -1, 0, 1'b0);

        // Start held high throughout: no restart in RUN, restart after DONE
        run_seq(1'b0, 4, -1, 0, 1'b1);
        @(negedge clk);
        chk("restart_valid", {31'd0, valid0}, 32'd1);
        chk("restart_cnt", {16'd0, count0}, 32'd0);
        chk("restart_ab", {30'd0, a0, b0}, 32'd0);
        start0 = 1'b0;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;

        // Zero seed falls back to 1 and walks away from zero
        start1 = 1'b1; mode1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("z_vec%0d", i), {18'd0, a1, b1}, {18'd0, exp1[i]});
            chk($sformatf("z_valid%0d", i), {31'd0, valid1}, 32'd1);
            @(negedge clk);
        end
        chk("z_done", {31'd0, done1}, 32'd1);
        chk("z_cnt", {16'd0, count1}, 32'd5);
        @(negedge clk);
        chk("z_idle", {31'd0, valid1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
